// File: rtl/uart_master_slave.sv
// UART bridge: serial host drives a 16-bit bus master through an escape
// protocol, while a CPU sees the same link as a two-register slave.
module uart_master_slave #(
    parameter int BAUDRATE = 1152000,
    parameter int SYS_FREQ = 25000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_master_data,
    output logic [7:0]  o_master_data,
    output logic [15:0] o_master_addr,
    input  logic        i_master_ack,
    output logic        o_master_we,
    output logic        o_master_cs,
    input  logic [7:0]  i_slave_data,
    output logic [7:0]  o_slave_data,
    input  logic        i_slave_addr,
    output logic        o_slave_ack,
    input  logic        i_slave_we,
    input  logic        i_slave_cs,
    output logic        o_int,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic        o_reset
);
    localparam int CPB = SYS_FREQ / BAUDRATE;
    localparam logic [15:0] CPB_M1 = 16'(CPB - 1);
    localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);
    localparam logic [7:0] ESC = 8'h1B;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic {T_IDLE, T_RUN} tx_state_t;
    typedef enum logic [2:0] {
        P_IDLE, P_ESC, P_ADDR_HI, P_ADDR_LO, P_WDATA, P_BUS, P_RESP
    } p_state_t;

    logic rx_m, rx_s;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_uart_rx;
            rx_s <= rx_m;
        end
    end

    rx_state_t rs, rs_n;
    logic [15:0] rcnt, rcnt_n;
    logic [2:0] rbit, rbit_n;
    logic [7:0] rsh, rsh_n;
    logic rx_done;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rs <= R_IDLE;
            rcnt <= '0;
            rbit <= '0;
            rsh <= '0;
        end else begin
            rs <= rs_n;
            rcnt <= rcnt_n;
            rbit <= rbit_n;
            rsh <= rsh_n;
        end
    end

    always_comb begin
        rs_n = rs;
        rcnt_n = rcnt;
        rbit_n = rbit;
        rsh_n = rsh;
        rx_done = 1'b0;
        case (rs)
            R_IDLE: begin
                if (!rx_s) begin
                    rs_n = R_START;
                    rcnt_n = '0;
                end
            end
            R_START: begin
                if (rcnt == HALF_M1) begin
                    rcnt_n = '0;
                    rbit_n = '0;
                    rs_n = rx_s ? R_IDLE : R_DATA;
                end else begin
                    rcnt_n = rcnt + 16'd1;
                end
            end
            R_DATA: begin
                if (rcnt == CPB_M1) begin
                    rcnt_n = '0;
                    rsh_n = {rx_s, rsh[7:1]};
                    rbit_n = rbit + 3'd1;
                    if (rbit == 3'd7) rs_n = R_STOP;
                end else begin
                    rcnt_n = rcnt + 16'd1;
                end
            end
            R_STOP: begin
                if (rcnt == CPB_M1) begin
                    // a framing error (stop bit low) silently drops the byte
                    rx_done = rx_s;
                    rs_n = R_IDLE;
                end else begin
                    rcnt_n = rcnt + 16'd1;
                end
            end
            default: rs_n = R_IDLE;
        endcase
    end

    tx_state_t ts, ts_n;
    logic [15:0] tcnt, tcnt_n;
    logic [3:0] tbit, tbit_n;
    logic [9:0] tsh, tsh_n;
    logic tx_load, tx_busy;
    logic [7:0] tx_byte;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ts <= T_IDLE;
            tcnt <= '0;
            tbit <= '0;
            tsh <= '1;
        end else begin
            ts <= ts_n;
            tcnt <= tcnt_n;
            tbit <= tbit_n;
            tsh <= tsh_n;
        end
    end

    always_comb begin
        ts_n = ts;
        tcnt_n = tcnt;
        tbit_n = tbit;
        tsh_n = tsh;
        case (ts)
            T_IDLE: begin
                if (tx_load) begin
                    ts_n = T_RUN;
                    tsh_n = {1'b1, tx_byte, 1'b0};
                    tcnt_n = '0;
                    tbit_n = '0;
                end
            end
            T_RUN: begin
                if (tcnt == CPB_M1) begin
                    tcnt_n = '0;
                    if (tbit == 4'd9) begin
                        ts_n = T_IDLE;
                    end else begin
                        tbit_n = tbit + 4'd1;
                        tsh_n = {1'b1, tsh[9:1]};
                    end
                end else begin
                    tcnt_n = tcnt + 16'd1;
                end
            end
            default: ts_n = T_IDLE;
        endcase
    end

    assign tx_busy = (ts == T_RUN);
    assign o_uart_tx = tx_busy ? tsh[0] : 1'b1;

    p_state_t ps, ps_n;
    logic [15:0] ptr, ptr_n;
    logic [7:0] hi, hi_n, wdata, wdata_n, rdata, rdata_n;
    logic we, we_n, host_rst, host_rst_n;
    logic deliver, resp_load;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ps <= P_IDLE;
            ptr <= '0;
            hi <= '0;
            wdata <= '0;
            rdata <= '0;
            we <= 1'b0;
            host_rst <= 1'b0;
        end else begin
            ps <= ps_n;
            ptr <= ptr_n;
            hi <= hi_n;
            wdata <= wdata_n;
            rdata <= rdata_n;
            we <= we_n;
            host_rst <= host_rst_n;
        end
    end

    always_comb begin
        ps_n = ps;
        ptr_n = ptr;
        hi_n = hi;
        wdata_n = wdata;
        rdata_n = rdata;
        we_n = we;
        host_rst_n = host_rst;
        deliver = 1'b0;
        resp_load = 1'b0;
        case (ps)
            P_IDLE: begin
                if (rx_done) begin
                    if (rsh == ESC) ps_n = P_ESC;
                    else deliver = 1'b1;
                end
            end
            P_ESC: begin
                if (rx_done) begin
                    ps_n = P_IDLE;
                    case (rsh)
                        8'h1B: deliver = 1'b1;
                        8'h41: ps_n = P_ADDR_HI;
                        8'h57: ps_n = P_WDATA;
                        8'h52: begin
                            we_n = 1'b0;
                            ps_n = P_BUS;
                        end
                        8'h58: host_rst_n = 1'b1;
                        8'h78: host_rst_n = 1'b0;
                        default: ;
                    endcase
                end
            end
            P_ADDR_HI: begin
                if (rx_done) begin
                    hi_n = rsh;
                    ps_n = P_ADDR_LO;
                end
            end
            P_ADDR_LO: begin
                if (rx_done) begin
                    ptr_n = {hi, rsh};
                    ps_n = P_IDLE;
                end
            end
            P_WDATA: begin
                if (rx_done) begin
                    wdata_n = rsh;
                    we_n = 1'b1;
                    ps_n = P_BUS;
                end
            end
            P_BUS: begin
                if (i_master_ack) begin
                    ptr_n = ptr + 16'd1;
                    if (!we) rdata_n = i_master_data;
                    ps_n = we ? P_IDLE : P_RESP;
                end
            end
            P_RESP: begin
                if (!tx_busy) begin
                    resp_load = 1'b1;
                    ps_n = P_IDLE;
                end
            end
            default: ps_n = P_IDLE;
        endcase
    end

    assign o_master_cs = (ps == P_BUS);
    assign o_master_addr = ptr;
    assign o_master_data = wdata;
    assign o_master_we = we;
    assign o_reset = host_rst;

    logic cs_q, cs_rise, rd_stat, rd_data, wr_data, slave_load;
    logic rx_valid, overrun;
    logic [7:0] rx_data;

    assign cs_rise = i_slave_cs & ~cs_q;
    assign rd_stat = cs_rise & ~i_slave_we & ~i_slave_addr;
    assign rd_data = cs_rise & ~i_slave_we & i_slave_addr;
    assign wr_data = cs_rise & i_slave_we & i_slave_addr;
    // host read responses win the transmitter over a same-cycle CPU write
    assign slave_load = wr_data & ~tx_busy & ~resp_load;
    assign tx_load = resp_load | slave_load;
    assign tx_byte = resp_load ? rdata : i_slave_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cs_q <= 1'b0;
            rx_valid <= 1'b0;
            overrun <= 1'b0;
            rx_data <= '0;
        end else begin
            cs_q <= i_slave_cs;
            if (rd_stat) overrun <= 1'b0;
            if (rd_data) rx_valid <= 1'b0;
            if (deliver) begin
                rx_data <= rsh;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_data) overrun <= 1'b1;
            end
        end
    end

    assign o_slave_ack = i_slave_cs;
    assign o_slave_data = i_slave_addr ? rx_data
                                       : {5'b0, overrun, tx_busy, rx_valid};
    assign o_int = rx_valid;

endmodule

// File: tb/tb_uart_master_slave.sv
// Directed bench for uart_master_slave: serial host commands, CPU slave
// registers, bus master cycles and reset abort.
module tb_uart_master_slave;
    localparam int CPB = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] m_rdata = '0;
    logic [7:0] m_wdata;
    logic [15:0] m_addr;
    logic m_ack = 1'b0;
    logic m_we, m_cs;
    logic [7:0] s_wdata = '0;
    logic [7:0] s_rdata;
    logic s_addr = 1'b0;
    logic s_ack;
    logic s_we = 1'b0;
    logic s_cs = 1'b0;
    logic irq;
    logic rx = 1'b1;
    logic tx;
    logic host_rst;

    int n_cmp = 0;
    int n_bad = 0;

    uart_master_slave dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_master_data(m_rdata),
        .o_master_data(m_wdata),
        .o_master_addr(m_addr),
        .i_master_ack(m_ack),
        .o_master_we(m_we),
        .o_master_cs(m_cs),
        .i_slave_data(s_wdata),
        .o_slave_data(s_rdata),
        .i_slave_addr(s_addr),
        .o_slave_ack(s_ack),
        .i_slave_we(s_we),
        .i_slave_cs(s_cs),
        .o_int(irq),
        .i_uart_rx(rx),
        .o_uart_tx(tx),
        .o_reset(host_rst)
    );

    always #20 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        @(negedge clk);
        s_cs = 1'b1;
        s_addr = a;
        s_we = 1'b0;
        #1;
        d = s_rdata;
        n_cmp++;
        if (s_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL slave_ack: got %b want 1", s_ack);
        end
        @(negedge clk);
        s_cs = 1'b0;
    endtask

    task automatic wait_cs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_cs === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL cs_timeout: got cs=%b want 1", m_cs);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b = '0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        repeat (CPB + CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b[i] = tx;
            repeat (CPB) @(negedge clk);
        end
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx, m_cs, m_we, host_rst, irq} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 10000",
                     {tx, m_cs, m_we, host_rst, irq});
        end
        n_cmp++;
        if ({m_addr, m_wdata} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h want 000000", {m_addr, m_wdata});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rx_byte;
        logic [7:0] d;
        send_byte(8'h55);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL rx_int_set: got %b want 1", irq);
        end
        cpu_read(1'b0, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_bad++;
            $display("FAIL rx_status1: got %h want 01", d);
        end
        cpu_read(1'b1, d);
        n_cmp++;
        if (d !== 8'h55) begin
            n_bad++;
            $display("FAIL rx_data: got %h want 55", d);
        end
        cpu_read(1'b0, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL rx_status2: got %h want 00", d);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_int_clr: got %b want 0", irq);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        send_byte(8'h11);
        send_byte(8'h22);
        cpu_read(1'b0, d);
        n_cmp++;
        if (d !== 8'h05) begin
            n_bad++;
            $display("FAIL ovr_status1: got %h want 05", d);
        end
        cpu_read(1'b0, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_bad++;
            $display("FAIL ovr_status2: got %h want 01", d);
        end
        cpu_read(1'b1, d);
        n_cmp++;
        if (d !== 8'h22) begin
            n_bad++;
            $display("FAIL ovr_data: got %h want 22", d);
        end
    endtask

    task automatic test_escape_cmds;
        logic [7:0] d;
        send_byte(8'h1B);
        send_byte(8'h58);
        n_cmp++;
        if (host_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL host_rst_set: got %b want 1", host_rst);
        end
        send_byte(8'h1B);
        send_byte(8'h78);
        n_cmp++;
        if (host_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL host_rst_clr: got %b want 0", host_rst);
        end
        send_byte(8'h1B);
        send_byte(8'h33);
        n_cmp++;
        if ({irq, m_cs, host_rst} !== 3'b000) begin
            n_bad++;
            $display("FAIL esc_unknown: got %b want 000", {irq, m_cs, host_rst});
        end
        send_byte(8'h1B);
        send_byte(8'h1B);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL esc_lit_int: got %b want 1", irq);
        end
        cpu_read(1'b1, d);
        n_cmp++;
        if (d !== 8'h1B) begin
            n_bad++;
            $display("FAIL esc_lit_data: got %h want 1b", d);
        end
    endtask

    task automatic test_bus_write;
        bit ok;
        int extra;
        send_byte(8'h1B);
        send_byte(8'h41);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h1B);
        send_byte(8'h57);
        send_byte(8'hAB);
        wait_cs(ok);
        n_cmp++;
        if ({m_we, m_addr, m_wdata} !== {1'b1, 16'h1234, 8'hAB}) begin
            n_bad++;
            $display("FAIL wr_cycle: got %b %h %h want 1 1234 ab",
                     m_we, m_addr, m_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_cs, m_addr} !== {1'b1, 16'h1234}) begin
                n_bad++;
                $display("FAIL wr_hold: got %b %h want 1 1234", m_cs, m_addr);
            end
        end
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        n_cmp++;
        if ({m_cs, m_addr} !== {1'b0, 16'h1235}) begin
            n_bad++;
            $display("FAIL wr_done: got %b %h want 0 1235", m_cs, m_addr);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_cs) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL wr_single: got %0d extra cs cycles want 0", extra);
        end
    endtask

    task automatic test_bus_read;
        bit ok;
        logic [7:0] b;
        send_byte(8'h1B);
        send_byte(8'h41);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h1B);
        send_byte(8'h52);
        wait_cs(ok);
        n_cmp++;
        if ({m_we, m_addr} !== {1'b0, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL rd_cycle: got %b %h want 0 ffff", m_we, m_addr);
        end
        m_rdata = 8'h5A;
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        m_rdata = 8'h00;
        n_cmp++;
        if ({m_cs, m_addr} !== {1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL rd_wrap: got %b %h want 0 0000", m_cs, m_addr);
        end
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== 8'h5A) begin
            n_bad++;
            $display("FAIL rd_resp: got %h ok=%b want 5a ok=1", b, ok);
        end
    endtask

    task automatic test_tx_frame;
        logic [7:0] b;
        int lows;
        bit start_ok, stop_ok, busy_hi, busy_lo;
        b = '0;
        lows = 0;
        start_ok = 1'b0;
        stop_ok = 1'b0;
        busy_hi = 1'b0;
        busy_lo = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        @(negedge clk);
        s_cs = 1'b1;
        s_addr = 1'b1;
        s_we = 1'b1;
        s_wdata = 8'h41;
        for (int j = 0; j <= 20 * CPB; j++) begin
            @(negedge clk);
            if (j == 4) begin
                s_addr = 1'b0;
                s_we = 1'b0;
            end
            #1;
            if (j == 0) start_ok = (tx === 1'b0);
            for (int k = 0; k < 8; k++)
                if (j == CPB * (k + 1) + CPB / 2) b[k] = tx;
            if (j == 9 * CPB + CPB / 2) stop_ok = (tx === 1'b1);
            if (j == 10 * CPB - 1) busy_hi = (s_rdata[1] === 1'b1);
            if (j == 10 * CPB) busy_lo = (s_rdata[1] === 1'b0);
            if (j > 10 * CPB && tx !== 1'b1) lows++;
        end
        s_cs = 1'b0;
        n_cmp++;
        if ({start_ok, b, stop_ok} !== {1'b1, 8'h41, 1'b1}) begin
            n_bad++;
            $display("FAIL tx_frame: got %b %h %b want 1 41 1",
                     start_ok, b, stop_ok);
        end
        n_cmp++;
        if ({busy_hi, busy_lo} !== 2'b11) begin
            n_bad++;
            $display("FAIL tx_busy_len: got %b%b want 11", busy_hi, busy_lo);
        end
        n_cmp++;
        if (lows != 0) begin
            n_bad++;
            $display("FAIL tx_single: got %0d low cycles want 0", lows);
        end
    endtask

    task automatic test_reset_abort;
        bit ok;
        int extra;
        send_byte(8'h1B);
        send_byte(8'h58);
        send_byte(8'h1B);
        send_byte(8'h57);
        send_byte(8'h77);
        wait_cs(ok);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_cs, host_rst, tx, m_addr} !== {3'b001, 16'h0}) begin
            n_bad++;
            $display("FAIL abort_now: got %b%b%b %h want 001 0000",
                     m_cs, host_rst, tx, m_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_cs || !tx) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_rx_byte();
        test_overrun();
        test_escape_cmds();
        test_bus_write();
        test_bus_read();
        test_tx_frame();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
